// File: rtl/fifo_uart_tx_ctrl_pkg.sv
// rtl/fifo_uart_tx_ctrl_pkg.sv - shared types and defaults for the FIFO-fed UART transmitter
package fifo_uart_tx_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} tx_state_t;

  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int FIFO_CAPACITY_BYTES  = 16;
  localparam int FIFO_CAPACITY_LOG2   = 4;

endpackage

// File: rtl/fifo_uart_tx_ctrl_baud.sv
// rtl/fifo_uart_tx_ctrl_baud.sv - bit-period counter, pulses bit_done on the last cycle of each bit
module uart_baud_counter
  import fifo_uart_tx_ctrl_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic bit_done
);

  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] count;

  assign bit_done = (count == LAST);

  always_ff @(posedge clk) begin
    if (!reset_n || clear || bit_done) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx_ctrl.sv
// rtl/fifo_uart_tx_ctrl.sv - pops one FIFO byte per frame and serialises it as 8N1/8N2 on txd
module fifo_uart_tx_ctrl
  import fifo_uart_tx_ctrl_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   tx_enable,
  input  logic                   fifo_read_ready,
  input  logic [7:0]             fifo_read_data,
  output logic                   fifo_read_enable,
  output logic                   txd,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] sent_count
);

  tx_state_t                 state;
  tx_state_t                 state_next;
  logic [UART_DATA_BITS-1:0] shift;
  logic [2:0]                bit_idx;
  logic                      bit_done;
  logic                      baud_clear;

  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (baud_clear),
    .bit_done (bit_done)
  );

  always_comb begin
    state_next       = state;
    fifo_read_enable = 1'b0;
    txd              = 1'b1;
    busy             = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        // Gated by reset so a held reset never pops and loses a byte.
        fifo_read_enable = tx_enable & fifo_read_ready & reset_n;
        if (fifo_read_enable) state_next = FETCH;
      end
      FETCH: state_next = START;
      START: begin
        txd = 1'b0;
        if (bit_done) state_next = DATA;
      end
      DATA: begin
        txd = shift[0];
        if (bit_done && bit_idx == 3'(UART_DATA_BITS - 1)) state_next = STOP;
      end
      STOP: begin
        if (bit_done && bit_idx == 3'(STOP_BITS - 1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    baud_clear = (state_next != state) || (state == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      shift      <= '0;
      bit_idx    <= '0;
      sent_count <= '0;
    end else begin
      state <= state_next;
      case (state)
        FETCH: begin
          shift   <= fifo_read_data;
          bit_idx <= '0;
        end
        DATA: begin
          if (bit_done) begin
            shift   <= shift >> 1;
            bit_idx <= (state_next == STOP) ? 3'd0 : bit_idx + 3'd1;
          end
        end
        STOP: begin
          // bit_idx is reused to count stop bits.
          if (bit_done) begin
            if (state_next == IDLE) begin
              bit_idx    <= '0;
              sent_count <= sent_count + 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fifo_uart_tx_ctrl.md
Name: fifo_uart_tx_ctrl

Overview:
Transmit-side controller that drains the byte FIFO into a UART line. It watches the FIFO's read_ready and pops one byte per frame, accounting for the FIFO's one-cycle registered read latency. It then serialises the byte as 8N1 (or 8N2) on txd. It sits between the CPU-side output FIFO and the board UART TX pin, and is the sole owner of the FIFO read port.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be >= 2
STOP_BITS, 1, number of stop bits, 1 or 2
COUNT_WIDTH, 16, width of the sent-byte counter

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous active-low reset
tx_enable  input  1  permits starting new frames; does not abort a frame in flight
fifo_read_ready  input  1  FIFO non-empty
fifo_read_data  input  8  FIFO registered read data; valid the cycle after fifo_read_enable
fifo_read_enable  output  1  pop strobe to FIFO, exactly one cycle per byte
txd  output  1  UART serial line, idle high
busy  output  1  high from pop until the last stop bit completes
sent_count  output  COUNT_WIDTH  number of completed frames; wraps modulo 2^COUNT_WIDTH

Behaviour:
- Reset: reset_n, synchronous, active-low; clock clk. On reset: state=IDLE, txd=1, busy=0, fifo_read_enable=0, sent_count=0, bit/baud counters=0.
- Reset mid-frame: txd returns to 1 at the next edge. The frame is abandoned and the popped byte is lost.
- States: IDLE, FETCH, START, DATA, STOP.
- IDLE: fifo_read_enable = tx_enable & fifo_read_ready, driven combinationally from state and inputs.
  - If 1, go to FETCH next cycle. Otherwise stay in IDLE.
  - txd=1, busy=0.
- FETCH: exactly one cycle. Latch fifo_read_data into an 8-bit shift register at the end of the cycle, then go to START. busy=1, txd=1.
- START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
- DATA: txd=shift[0] (LSB first). Each bit lasts CLKS_PER_BIT cycles, then shift right and increment bit_idx. After bit 7, go to STOP.
- STOP: txd=1 for STOP_BITS*CLKS_PER_BIT cycles. On the final cycle, increment sent_count and go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets to 0 on every state change. Width is $clog2(CLKS_PER_BIT).
- Latency: pop in cycle T (IDLE), FETCH in T+1, first start-bit cycle in T+2.
  - Frame length = (1+8+STOP_BITS)*CLKS_PER_BIT cycles.
  - Minimum inter-frame idle-high gap = 2 cycles (IDLE + FETCH).
- Empty FIFO: no pop, txd held 1. fifo_read_enable is never asserted while fifo_read_ready=0.
- tx_enable falling mid-frame: the current frame completes and no further pop occurs.
- FIFO written in the same cycle it becomes non-empty: handled by the FETCH stage; no bypass needed.
- The block pops at most one byte per frame, never more than one pop outstanding.

Decomposition:
- Shared package: tx_state_t enum {IDLE, FETCH, START, DATA, STOP}; UART_DATA_BITS=8 constant; default CLKS_PER_BIT constant alongside FIFO_CAPACITY_* defines.
- One sub-module: uart_baud_counter, with CLKS_PER_BIT parameter, clear input, and bit_done output. The FSM, shift register and counters stay in the top module.

Test Plan:
- Reset with FIFO empty, tx_enable=1, 50 cycles -> txd=1, busy=0, fifo_read_enable=0, sent_count=0 throughout.
- CLKS_PER_BIT=4, write 0x55 -> one pop pulse; txd two cycles later = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles; sent_count=1; busy low after stop bit.
- CLKS_PER_BIT=4, write 0xA3,0x0F back-to-back -> two pops; frames LSB-first; exactly 2 idle-high cycles between frames; sent_count=2.
- tx_enable=0 with 3 bytes queued -> no pops, txd=1. Raise tx_enable -> 3 frames sent; deassert during frame 2 -> frame 2 completes, byte 3 remains in FIFO (read_ready=1).
- reset_n low during DATA bit 3 of 0x00 -> txd=1 next cycle, busy=0, sent_count=0; the following byte transmits cleanly.
- STOP_BITS=2, CLKS_PER_BIT=4, byte 0xFF -> stop high for 8 cycles before next start; COUNT_WIDTH=4 with 17 frames -> sent_count=1.
